issue_select_pipe: RTL and testbench
====================================

Name: issue_select_pipe

Overview:
- Generic, parametrised issue-select stage for one functional-unit class.
- Sits between one reservation-station bank and that class's FU ports; one instance per class (ALU, MULT, BRANCH, MEM).
- Picks up to NUM_PORTS ready RS entries per cycle, oldest-first by ROB age, and latches them into per-port output registers.
- Unlike the fixed-priority generation, output slots use a valid/ready handshake, so a stalled FU holds its slot without losing the entry.

Parameters:
- NUM_ENTRIES, 8, RS entries in the bank (>=2).
- NUM_PORTS, 2, FU issue ports for this class (1..NUM_ENTRIES).
- ENTRY_W, 64, width of one opaque RS entry payload.
- AGE_W, 5, ROB index width used as the age tag.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- flush  in  1  mispredict flush; synchronous, active-high.
- rs_valid  in  NUM_ENTRIES  entry occupied.
- rs_ready  in  NUM_ENTRIES  both sources ready.
- rs_age  in  NUM_ENTRIES*AGE_W  ROB index per entry.
- rs_payload  in  NUM_ENTRIES*ENTRY_W  entry contents.
- rob_head  in  AGE_W  current ROB head; oldest reference point.
- rs_clear  out  NUM_ENTRIES  one-hot-per-grant mask of entries issued this cycle (RS frees them at the edge).
- out_valid  out  NUM_PORTS  port slot holds an issued entry.
- out_ready  in  NUM_PORTS  FU accepts slot this cycle.
- out_payload  out  NUM_PORTS*ENTRY_W  issued entry per port.
- out_src_idx  out  NUM_PORTS*$clog2(NUM_ENTRIES)  RS index the slot came from.

Behaviour:
- Reset (reset==0 at posedge): out_valid=0, out_payload=0, out_src_idx=0, all counters 0. rs_clear is forced 0 while reset==0.
- Candidate mask: rs_valid & rs_ready.
- Relative age: rel = (rs_age - rob_head) mod 2^AGE_W. Smaller rel is older. Ties (illegal) are broken by lower RS index.
- Free port: !out_valid[p] | out_ready[p].
- Selection (combinational, same cycle):
  - Let F = number of free ports. Select the min(F, popcount(candidates)) oldest candidates.
  - The k-th oldest candidate goes to the k-th lowest-index free port.
  - No entry is granted to two ports.
- rs_clear[i]=1 iff entry i is granted this cycle. Latency: grant-to-output is 1 cycle.
- Slot register at posedge, per port p:
  - Granted: load payload and index, out_valid[p]=1.
  - Else if out_ready[p]: out_valid[p]=0.
  - Else: hold (payload stable while valid & !ready).
- Handshake: a transfer occurs when out_valid & out_ready. Transfer and reload of the same port in one cycle is legal, giving back-to-back issue.
- Flush (flush==1):
  - rs_clear=0 that cycle; no grants.
  - Next edge: out_valid=0 on all ports regardless of out_ready.
  - Reset has priority over flush.
- Boundaries:
  - No candidates: rs_clear=0; ports drain per handshake.
  - All ports stalled: F=0, no grants, rs_clear=0.
  - ROB wrap: age 31 with head 30 is older than age 2 (rel 1 vs 4).
  - NUM_PORTS==NUM_ENTRIES: every candidate is granted if ports are free.

Optional Feature:
- Macro ISSUE_SELECT_PERF_EN.
- Defined: adds outputs perf_issued (32 bits, total grants, saturating) and perf_stall_cycles (32 bits, cycles with >=1 candidate and F==0, saturating). Both are cleared by reset and unaffected by flush.
- Undefined: no ports, no counters, identical functional behaviour.

Decomposition:
- Shared package holds: RS_BANK_IDX width function, AGE_T typedef, ISSUE_SLOT struct (valid, src_idx, payload), and a rel_age function.
- One sub-module, age_oldest_pick: given a mask and ages, it outputs a one-hot of the oldest. It is instantiated NUM_PORTS times in a chain, with each stage masking off the previous picks.

Test Plan (NUM_ENTRIES=8, NUM_PORTS=2, AGE_W=5):
- Reset: hold reset=0 for 2 cycles with all candidates ready -> out_valid=00, rs_clear=0; after release, the two oldest issue on the next edge.
- Oldest-first: head=0; entries 3,5,6 ready with ages 9,2,4 -> rs_clear=0x60 (entries 5,6); port0 gets idx5, port1 gets idx6, one cycle later.
- Wrap: head=30; entry0 age 2, entry1 age 31, only port0 free -> entry1 granted, rs_clear=0x02.
- Stall: port0 valid with out_ready=0 for 3 cycles, port1 free, entries 0,1 ready -> only port1 refilled, port0 payload unchanged, then port0 refills when out_ready=1.
- Flush: both ports valid, flush=1 with candidates ready -> rs_clear=0; next cycle out_valid=00.
- Back-to-back: both out_ready=1 every cycle, 4 ready entries -> 2 issues per cycle for 2 cycles, no bubble.

Source files
------------

// File: rtl/issue_select_pipe_pkg.sv
// Shared types and helpers for the issue-select stage.
//
// Contents:
//   rs_bank_idx_w  - bit width needed to index an RS bank of a given depth
//   age_t          - ROB-index age tag at the default width
//   issue_slot_t   - one issued output slot (valid, source index, payload)
//   rel_age        - age of a ROB index relative to the ROB head, modulo 2^width
package issue_select_pipe_pkg;

    localparam int unsigned DefAgeW    = 5;
    localparam int unsigned DefEntryW  = 64;
    localparam int unsigned DefEntries = 8;

    function automatic int rs_bank_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DefIdxW = rs_bank_idx_w(DefEntries);

    typedef logic [DefAgeW-1:0] age_t;

    typedef struct packed {
        logic                 valid;
        logic [DefIdxW-1:0]   src_idx;
        logic [DefEntryW-1:0] payload;
    } issue_slot_t;

    // Distance from the ROB head; smaller means older. Wraps at 2^width.
    function automatic logic [31:0] rel_age(input logic [31:0] age,
                                            input logic [31:0] head,
                                            input int unsigned width);
        logic [31:0] mask;
        mask = (32'd1 << width) - 32'd1;
        return (age - head) & mask;
    endfunction

endpackage

// File: rtl/issue_select_pipe_age_oldest_pick.sv
// Oldest-entry picker: one stage of the issue-select chain.
//
// Ports:
//   i_mask [N]        - entries eligible for this stage
//   i_rel  [N*AGE_W]  - relative age per entry (smaller is older)
//   o_pick [N]        - one-hot of the oldest eligible entry (all zero if none)
//   o_any             - at least one entry was eligible
module issue_select_pipe_age_oldest_pick #(
    parameter int unsigned N     = 8,
    parameter int unsigned AGE_W = 5
) (
    input  logic [N-1:0]       i_mask,
    input  logic [N*AGE_W-1:0] i_rel,
    output logic [N-1:0]       o_pick,
    output logic               o_any
);

    logic             w_found;
    logic [AGE_W-1:0] w_best;
    int               w_sel;

    always_comb begin
        w_found = 1'b0;
        w_best  = '0;
        w_sel   = 0;
        o_pick  = '0;
        // Strict less-than keeps the lowest index on equal ages.
        for (int i = 0; i < N; i++) begin
            if (i_mask[i] && (!w_found || (i_rel[i*AGE_W +: AGE_W] < w_best))) begin
                w_found = 1'b1;
                w_best  = i_rel[i*AGE_W +: AGE_W];
                w_sel   = i;
            end
        end
        o_pick[w_sel] = w_found;
        o_any         = w_found;
    end

endmodule

// File: rtl/issue_select_pipe.sv
// Issue-select stage for one functional-unit class.
//
// Selects up to NUM_PORTS ready RS entries per cycle, oldest-first by ROB age,
// and latches them into per-port valid/ready output slots. A stalled slot holds
// its entry until the FU accepts it.
//
// Optional feature: define ISSUE_SELECT_PERF_EN to add saturating counters
// o_perf_issued (total grants) and o_perf_stall_cycles (cycles with a candidate
// but no free port).
//
// Ports:
//   i_clock         - clock, all state on posedge
//   i_reset         - synchronous active-low reset
//   i_flush         - mispredict flush, synchronous active-high
//   i_rs_valid      - RS entry occupied
//   i_rs_ready      - RS entry sources ready
//   i_rs_age        - ROB index per entry
//   i_rs_payload    - entry contents
//   i_rob_head      - current ROB head
//   o_rs_clear      - entries granted this cycle
//   o_out_valid     - slot holds an issued entry
//   i_out_ready     - FU accepts slot
//   o_out_payload   - issued entry per port
//   o_out_src_idx   - RS index per port
module issue_select_pipe
    import issue_select_pipe_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 8,
    parameter int unsigned NUM_PORTS   = 2,
    parameter int unsigned ENTRY_W     = 64,
    parameter int unsigned AGE_W       = 5
) (
    input  logic                                            i_clock,
    input  logic                                            i_reset,
    input  logic                                            i_flush,
    input  logic [NUM_ENTRIES-1:0]                          i_rs_valid,
    input  logic [NUM_ENTRIES-1:0]                          i_rs_ready,
    input  logic [NUM_ENTRIES*AGE_W-1:0]                    i_rs_age,
    input  logic [NUM_ENTRIES*ENTRY_W-1:0]                  i_rs_payload,
    input  logic [AGE_W-1:0]                                i_rob_head,
    output logic [NUM_ENTRIES-1:0]                          o_rs_clear,
    output logic [NUM_PORTS-1:0]                            o_out_valid,
    input  logic [NUM_PORTS-1:0]                            i_out_ready,
    output logic [NUM_PORTS*ENTRY_W-1:0]                    o_out_payload,
    output logic [NUM_PORTS*rs_bank_idx_w(NUM_ENTRIES)-1:0] o_out_src_idx
`ifdef ISSUE_SELECT_PERF_EN
    ,
    output logic [31:0]                                     o_perf_issued,
    output logic [31:0]                                     o_perf_stall_cycles
`endif
);

    localparam int          IdxW  = rs_bank_idx_w(NUM_ENTRIES);
    localparam int unsigned RankW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0]         r_valid;
    logic [ENTRY_W-1:0]           r_payload [NUM_PORTS];
    logic [IdxW-1:0]              r_src_idx [NUM_PORTS];

    logic [NUM_ENTRIES-1:0]       w_cand;
    logic [NUM_ENTRIES*AGE_W-1:0] w_rel;
    logic [NUM_ENTRIES-1:0]       w_avail    [NUM_PORTS];
    logic [NUM_ENTRIES-1:0]       w_pick     [NUM_PORTS];
    logic                         w_pick_any [NUM_PORTS];
    logic [NUM_PORTS-1:0]         w_free;
    logic                         w_grant_en;
    logic [RankW:0]               w_rank;
    logic [NUM_PORTS-1:0]         w_grant;
    logic [NUM_ENTRIES-1:0]       w_port_pick [NUM_PORTS];
    logic [ENTRY_W-1:0]           w_port_pay  [NUM_PORTS];
    logic [IdxW-1:0]              w_port_idx  [NUM_PORTS];
    logic [NUM_ENTRIES-1:0]       w_clear;

    assign w_cand     = i_rs_valid & i_rs_ready;
    assign w_free     = ~r_valid | i_out_ready;
    assign w_grant_en = i_reset & ~i_flush;

    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_rel
        assign w_rel[i*AGE_W +: AGE_W] =
            AGE_W'(rel_age(32'(i_rs_age[i*AGE_W +: AGE_W]), 32'(i_rob_head), AGE_W));
    end

    // Stage k sees the candidates left after stages 0..k-1, so it finds the
    // k-th oldest.
    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_chain
        if (k == 0) begin : g_first
            assign w_avail[k] = w_cand;
        end else begin : g_next
            assign w_avail[k] = w_avail[k-1] & ~w_pick[k-1];
        end

        issue_select_pipe_age_oldest_pick #(
            .N     (NUM_ENTRIES),
            .AGE_W (AGE_W)
        ) u_age_oldest_pick (
            .i_mask (w_avail[k]),
            .i_rel  (w_rel),
            .o_pick (w_pick[k]),
            .o_any  (w_pick_any[k])
        );
    end

    // The k-th free port (by index) takes the k-th oldest candidate.
    always_comb begin
        w_rank  = '0;
        w_grant = '0;
        w_clear = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_port_pick[p] = '0;
            if (w_free[p]) begin
                if (w_grant_en && w_pick_any[w_rank[RankW-1:0]]) begin
                    w_grant[p]     = 1'b1;
                    w_port_pick[p] = w_pick[w_rank[RankW-1:0]];
                end
                w_rank = w_rank + (RankW+1)'(1);
            end
            w_clear = w_clear | w_port_pick[p];
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_port_pay[p] = '0;
            w_port_idx[p] = '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (w_port_pick[p][i]) begin
                    w_port_idx[p] = IdxW'(i);
                end
                w_port_pay[p] = w_port_pay[p] |
                    ({ENTRY_W{w_port_pick[p][i]}} & i_rs_payload[i*ENTRY_W +: ENTRY_W]);
            end
        end
    end

    assign o_rs_clear = w_clear;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_valid <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_payload[p] <= '0;
                r_src_idx[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_grant[p]) begin
                    r_valid[p]   <= 1'b1;
                    r_payload[p] <= w_port_pay[p];
                    r_src_idx[p] <= w_port_idx[p];
                end else if (i_flush || i_out_ready[p]) begin
                    r_valid[p] <= 1'b0;
                end
            end
        end
    end

    assign o_out_valid = r_valid;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_out
        assign o_out_payload[p*ENTRY_W +: ENTRY_W] = r_payload[p];
        assign o_out_src_idx[p*IdxW +: IdxW]       = r_src_idx[p];
    end

`ifdef ISSUE_SELECT_PERF_EN
    logic [31:0] r_perf_issued;
    logic [31:0] r_perf_stall;
    logic [32:0] w_issued_sum;
    logic        w_stall;

    assign w_issued_sum = {1'b0, r_perf_issued} + 33'($countones(w_grant));
    assign w_stall      = (|w_cand) && (w_free == '0);

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_perf_issued <= '0;
            r_perf_stall  <= '0;
        end else begin
            r_perf_issued <= w_issued_sum[32] ? 32'hFFFF_FFFF : w_issued_sum[31:0];
            if (w_stall && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign o_perf_issued       = r_perf_issued;
    assign o_perf_stall_cycles = r_perf_stall;
`endif

endmodule

// File: tb/tb_issue_select_pipe.sv
// Self-checking bench for issue_select_pipe (8 entries, 2 ports, 5-bit ages).
module tb_issue_select_pipe;

    localparam int N  = 8;
    localparam int P  = 2;
    localparam int EW = 64;
    localparam int AW = 5;
    localparam int IW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic [N-1:0]    rs_valid;
    logic [N-1:0]    rs_ready;
    logic [N*AW-1:0] rs_age;
    logic [N*EW-1:0] rs_payload;
    logic [AW-1:0]   head;
    logic [N-1:0]    rs_clear;
    logic [P-1:0]    out_valid;
    logic [P-1:0]    out_ready;
    logic [P*EW-1:0] out_payload;
    logic [P*IW-1:0] out_src_idx;
`ifdef ISSUE_SELECT_PERF_EN
    logic [31:0]     perf_issued;
    logic [31:0]     perf_stall;
`endif

    always #5 clk = ~clk;

    issue_select_pipe #(
        .NUM_ENTRIES (N),
        .NUM_PORTS   (P),
        .ENTRY_W     (EW),
        .AGE_W       (AW)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst_n),
        .i_flush       (flush),
        .i_rs_valid    (rs_valid),
        .i_rs_ready    (rs_ready),
        .i_rs_age      (rs_age),
        .i_rs_payload  (rs_payload),
        .i_rob_head    (head),
        .o_rs_clear    (rs_clear),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_out_payload (out_payload),
        .o_out_src_idx (out_src_idx)
`ifdef ISSUE_SELECT_PERF_EN
        ,
        .o_perf_issued       (perf_issued),
        .o_perf_stall_cycles (perf_stall)
`endif
    );

    // Reference model state: one record per output slot.
    logic [P-1:0]  m_valid;
    logic [IW-1:0] m_idx [P];
    logic [EW-1:0] m_pay [P];
    int            g_entry [P];
    logic [N-1:0]  g_clear;
    logic          g_stall;
    longint        m_issued;
    longint        m_stall;

    int n_vec;
    int n_err;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at vector %0d: got %0h, expected %0h", name, n_vec, act, exp);
        end
    endtask

    // Sort candidates by (relative age, index); hand them to free ports in order.
    task automatic compute_grants();
        int keys[$];
        int freep[$];
        int n;
        int e;
        g_clear = '0;
        g_stall = 1'b0;
        for (int p = 0; p < P; p++) g_entry[p] = -1;
        for (int i = 0; i < N; i++) begin
            if (rs_valid[i] && rs_ready[i]) begin
                keys.push_back(((int'(rs_age[i*AW +: AW]) - int'(head)) & 31) * N + i);
            end
        end
        keys.sort();
        for (int p = 0; p < P; p++) begin
            if (!m_valid[p] || out_ready[p]) freep.push_back(p);
        end
        g_stall = (keys.size() > 0) && (freep.size() == 0);
        if (rst_n && !flush) begin
            n = (keys.size() < freep.size()) ? keys.size() : freep.size();
            for (int k = 0; k < n; k++) begin
                e = keys[k] % N;
                g_entry[freep[k]] = e;
                g_clear[e] = 1'b1;
            end
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_valid  = '0;
            m_issued = 0;
            m_stall  = 0;
            for (int p = 0; p < P; p++) begin
                m_idx[p] = '0;
                m_pay[p] = '0;
            end
        end else begin
            m_issued += $countones(g_clear);
            if (g_stall) m_stall++;
            for (int p = 0; p < P; p++) begin
                if (g_entry[p] >= 0) begin
                    m_valid[p] = 1'b1;
                    m_idx[p]   = IW'(g_entry[p]);
                    m_pay[p]   = rs_payload[g_entry[p]*EW +: EW];
                end else if (flush || out_ready[p]) begin
                    m_valid[p] = 1'b0;
                end
            end
        end
    endtask

    // Inputs are already applied (just after a negedge); returns at the next negedge.
    task automatic step();
        compute_grants();
        #1;
        check("rs_clear", 128'(rs_clear), 128'(g_clear));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        for (int p = 0; p < P; p++) begin
            check("out_valid", 128'(out_valid[p]), 128'(m_valid[p]));
            check("out_src_idx", 128'(out_src_idx[p*IW +: IW]), 128'(m_idx[p]));
            check("out_payload", 128'(out_payload[p*EW +: EW]), 128'(m_pay[p]));
        end
        n_vec++;
    endtask

    typedef struct {
        logic          rst_n;
        logic          flush;
        logic [N-1:0]  v;
        logic [N-1:0]  r;
        logic [N*AW-1:0] ages;
        logic [AW-1:0] head;
        logic [P-1:0]  ordy;
        logic [N-1:0]  exp_clear;
        logic [P-1:0]  exp_valid;
        logic [IW-1:0] exp_idx0;
        logic [IW-1:0] exp_idx1;
    } vec_t;

    function automatic logic [N*AW-1:0] ages8(input int a0, a1, a2, a3, a4, a5, a6, a7);
        return {AW'(a7), AW'(a6), AW'(a5), AW'(a4), AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endfunction

    function automatic vec_t mkv(input logic rn, fl, input logic [7:0] v, r,
                                 input logic [39:0] ages, input logic [4:0] hd,
                                 input logic [1:0] ordy, input logic [7:0] ec,
                                 input logic [1:0] ev, input logic [2:0] i0, i1);
        vec_t t;
        t.rst_n = rn; t.flush = fl; t.v = v; t.r = r; t.ages = ages; t.head = hd;
        t.ordy = ordy; t.exp_clear = ec; t.exp_valid = ev; t.exp_idx0 = i0; t.exp_idx1 = i1;
        return t;
    endfunction

    vec_t tbl[17];

    initial begin
        logic [39:0] dflt;
        n_vec   = 0;
        n_err   = 0;
        m_valid = '0;
        m_issued = 0;
        m_stall  = 0;
        for (int p = 0; p < P; p++) begin
            m_idx[p] = '0;
            m_pay[p] = '0;
        end
        dflt = ages8(0, 1, 2, 3, 4, 5, 6, 7);

        //            rst flush valid  ready  ages                            head  ordy  clear  valid i0 i1
        tbl[0]  = mkv(0, 0, 8'hFF, 8'hFF, dflt,                           5'd0,  2'b00, 8'h00, 2'b00, 0, 0);
        tbl[1]  = mkv(0, 0, 8'hFF, 8'hFF, dflt,                           5'd0,  2'b00, 8'h00, 2'b00, 0, 0);
        tbl[2]  = mkv(1, 0, 8'hFF, 8'hFF, dflt,                           5'd0,  2'b00, 8'h03, 2'b11, 0, 1);
        tbl[3]  = mkv(1, 0, 8'h68, 8'h68, ages8(0, 0, 0, 9, 0, 2, 4, 0),  5'd0,  2'b11, 8'h60, 2'b11, 5, 6);
        tbl[4]  = mkv(1, 0, 8'h03, 8'h03, ages8(2, 31, 0, 0, 0, 0, 0, 0), 5'd30, 2'b01, 8'h02, 2'b11, 1, 6);
        tbl[5]  = mkv(1, 0, 8'h03, 8'h03, dflt,                           5'd0,  2'b10, 8'h01, 2'b11, 1, 0);
        tbl[6]  = mkv(1, 0, 8'h02, 8'h02, dflt,                           5'd0,  2'b10, 8'h02, 2'b11, 1, 1);
        tbl[7]  = mkv(1, 0, 8'h00, 8'h00, dflt,                           5'd0,  2'b10, 8'h00, 2'b01, 1, 0);
        tbl[8]  = mkv(1, 0, 8'h0C, 8'h0C, dflt,                           5'd0,  2'b01, 8'h0C, 2'b11, 2, 3);
        tbl[9]  = mkv(1, 1, 8'hF0, 8'hF0, dflt,                           5'd0,  2'b00, 8'h00, 2'b00, 0, 0);
        tbl[10] = mkv(1, 0, 8'hF0, 8'hF0, dflt,                           5'd0,  2'b11, 8'h30, 2'b11, 4, 5);
        tbl[11] = mkv(1, 0, 8'hC0, 8'hC0, dflt,                           5'd0,  2'b11, 8'hC0, 2'b11, 6, 7);
        tbl[12] = mkv(1, 0, 8'h00, 8'h00, dflt,                           5'd0,  2'b11, 8'h00, 2'b00, 0, 0);
        tbl[13] = mkv(1, 0, 8'h03, 8'h03, dflt,                           5'd0,  2'b00, 8'h03, 2'b11, 0, 1);
        tbl[14] = mkv(1, 0, 8'hFC, 8'hFC, dflt,                           5'd0,  2'b00, 8'h00, 2'b11, 0, 1);
        tbl[15] = mkv(1, 0, 8'hFF, 8'h00, dflt,                           5'd0,  2'b11, 8'h00, 2'b00, 0, 0);
        tbl[16] = mkv(0, 1, 8'hFF, 8'hFF, dflt,                           5'd0,  2'b00, 8'h00, 2'b00, 0, 0);

        for (int i = 0; i < N; i++) begin
            rs_payload[i*EW +: EW] = {32'hC0DE_0000 | 32'(i), 32'h1234_5678 ^ 32'(i)};
        end
        rst_n = 1'b0; flush = 1'b0; rs_valid = '0; rs_ready = '0;
        rs_age = '0; head = '0; out_ready = '0;
        @(negedge clk);

        for (int t = 0; t < 17; t++) begin
            rst_n     = tbl[t].rst_n;
            flush     = tbl[t].flush;
            rs_valid  = tbl[t].v;
            rs_ready  = tbl[t].r;
            rs_age    = tbl[t].ages;
            head      = tbl[t].head;
            out_ready = tbl[t].ordy;
            #1;
            check("tbl_rs_clear", 128'(rs_clear), 128'(tbl[t].exp_clear));
            step();
            check("tbl_out_valid", 128'(out_valid), 128'(tbl[t].exp_valid));
            if (tbl[t].exp_valid[0]) check("tbl_idx0", 128'(out_src_idx[2:0]), 128'(tbl[t].exp_idx0));
            if (tbl[t].exp_valid[1]) check("tbl_idx1", 128'(out_src_idx[5:3]), 128'(tbl[t].exp_idx1));
        end

        // Randomised traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            rst_n     = ($urandom_range(0, 59) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            rs_valid  = N'($urandom);
            rs_ready  = N'($urandom) | N'($urandom);
            head      = AW'($urandom);
            out_ready = P'($urandom);
            for (int i = 0; i < N; i++) begin
                rs_age[i*AW +: AW]     = AW'($urandom);
                rs_payload[i*EW +: EW] = {$urandom, $urandom};
            end
            step();
        end

`ifdef ISSUE_SELECT_PERF_EN
        check("perf_issued", 128'(perf_issued), 128'(m_issued));
        check("perf_stall", 128'(perf_stall), 128'(m_stall));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
